// File: rtl/fetch_ctrl_if.sv
// Handshake bundle between ID/IF and the fetch sequencer.
// The slave side is fetch_ctrl; the master side is the surrounding pipeline.
interface fetch_ctrl_if;
  logic        stall_req;
  logic        cbr_taken;
  logic [31:0] cbr_target;
  logic [31:0] instr_in;
  logic [31:0] pc_next_if;
  logic        resume;
  logic        wr_pc;
  logic [31:0] wr_pc_val;
  logic        if_en;
  logic        flush;
  logic        halted;
  logic [1:0]  state;
  logic [15:0] redirect_cnt;

  modport master (
    output stall_req, cbr_taken, cbr_target, instr_in, pc_next_if, resume,
    input  wr_pc, wr_pc_val, if_en, flush, halted, state, redirect_cnt
  );

  modport slave (
    input  stall_req, cbr_taken, cbr_target, instr_in, pc_next_if, resume,
    output wr_pc, wr_pc_val, if_en, flush, halted, state, redirect_cnt
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction Fetch sequencer: boot window, ID stalls, taken-branch redirects
// and HALT/resume. Owns the PC write port and the IF enable/flush controls.
module fetch_ctrl #(
  parameter int unsigned BOOT_CYCLES  = 2,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [6:0]  HALT_OPCODE  = 7'b1111111
) (
  input logic         clk,
  input logic         reset,
  fetch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } state_e;

  localparam logic [7:0]  BOOT_INIT = 8'(BOOT_CYCLES - 1);
  localparam logic [31:0] RESET_PC  = {RESET_VECTOR[31:2], 2'b00};

  state_e      state_q, state_d;
  logic [7:0]  boot_cnt_q, boot_cnt_d;
  logic [15:0] redirect_cnt_q;
  logic        redirect_accept;

  logic        wr_pc;
  logic [31:0] wr_pc_val;
  logic        if_en;
  logic        flush;
  logic        halted;

  logic        is_halt_word;
  logic [31:0] branch_pc;
  logic [31:0] seq_pc;

  assign is_halt_word = (bus.instr_in[31:25] == HALT_OPCODE);
  assign branch_pc    = {bus.cbr_target[31:2], 2'b00};
  assign seq_pc       = {bus.pc_next_if[31:2], 2'b00};

  // Low address bits and the instruction operand fields are deliberately unused.
  logic unused_bits;
  assign unused_bits = ^{bus.cbr_target[1:0], bus.pc_next_if[1:0], bus.instr_in[24:0]};

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no path
    // through the case below leaves a signal unassigned (which would infer a latch).
    state_d         = state_q;
    boot_cnt_d      = boot_cnt_q;
    redirect_accept = 1'b0;
    wr_pc           = 1'b0;
    wr_pc_val       = seq_pc;
    if_en           = 1'b0;
    flush           = 1'b0;
    halted          = 1'b0;

    unique case (state_q)
      BOOT: begin
        wr_pc     = 1'b1;
        wr_pc_val = RESET_PC;
        flush     = 1'b1;
        if (boot_cnt_q == 8'd0) begin
          state_d = RUN;
        end else begin
          boot_cnt_d = boot_cnt_q - 8'd1;
        end
      end

      RUN, FLUSH: begin
        // A redirect outranks HALT and stall: whatever else is in flight is wrong-path.
        if (bus.cbr_taken) begin
          wr_pc           = 1'b1;
          wr_pc_val       = branch_pc;
          flush           = 1'b1;
          redirect_accept = 1'b1;
          state_d         = FLUSH;
        end else if (is_halt_word) begin
          flush   = 1'b1;
          state_d = HALT;
        end else if (bus.stall_req) begin
          // Hold the current state so a pending FLUSH bubble survives the stall.
          state_d = state_q;
        end else begin
          wr_pc     = 1'b1;
          wr_pc_val = seq_pc;
          if_en     = 1'b1;
          flush     = (state_q == FLUSH);
          state_d   = RUN;
        end
      end

      HALT: begin
        halted = 1'b1;
        if (bus.resume) begin
          state_d = RUN;
        end
      end

      default: state_d = BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= BOOT;
      boot_cnt_q     <= BOOT_INIT;
      redirect_cnt_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      if (redirect_accept && (redirect_cnt_q != 16'hFFFF)) begin
        redirect_cnt_q <= redirect_cnt_q + 16'd1;
      end
    end
  end

  assign bus.wr_pc        = wr_pc;
  assign bus.wr_pc_val    = wr_pc_val;
  assign bus.if_en        = if_en;
  assign bus.flush        = flush;
  assign bus.halted       = halted;
  assign bus.state        = state_q;
  assign bus.redirect_cnt = redirect_cnt_q;

endmodule
